// File: rtl/uniter_rr.sv
// N-to-1 valid/ready stream merger with fixed-select or round-robin arbitration,
// packet locking and a registered slave-side output stage.
module uniter_rr #(
  parameter  int unsigned PORTS_N = 4,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned SEL_W   = (PORTS_N > 1) ? $clog2(PORTS_N) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_mode,
  input  logic [SEL_W-1:0]            i_sel,
  input  logic [PORTS_N-1:0]          i_master_valid,
  output logic [PORTS_N-1:0]          o_master_ready,
  input  logic [PORTS_N*DATA_W-1:0]   i_master_data,
  input  logic [PORTS_N-1:0]          i_master_last,
  output logic                        o_slave_valid,
  input  logic                        i_slave_ready,
  output logic [DATA_W-1:0]           o_slave_data,
  output logic                        o_slave_last,
  output logic [SEL_W-1:0]            o_slave_id
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [SEL_W-1:0]  lock_id;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_gnt;
  logic              rr_vld;
  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_next;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_last;
  logic              can_acc;
  logic              xfer;

  // Round-robin scan starting at rr_ptr; the smallest offset with valid wins
  always_comb begin
    int unsigned idx;
    idx    = 0;
    rr_gnt = '0;
    rr_vld = 1'b0;
    for (int unsigned k = 0; k < PORTS_N; k++) begin
      idx = (32'(rr_ptr) + k) % PORTS_N;
      if (!rr_vld && i_master_valid[SEL_W'(idx)]) begin
        rr_gnt = SEL_W'(idx);
        rr_vld = 1'b1;
      end
    end
  end

  // Grant selection: a locked packet owner overrides mode and sel
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (state == LOCKED) begin
      gnt     = lock_id;
      gnt_vld = i_master_valid[lock_id];
    end else if (!i_mode) begin
      gnt = i_sel;
      if (32'(i_sel) < PORTS_N) gnt_vld = i_master_valid[i_sel];
    end else begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end
  end

  // Payload mux; an out-of-range gnt never transfers, so it reads as zero
  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int unsigned g = 0; g < PORTS_N; g++) begin
      if (gnt == SEL_W'(g)) begin
        gnt_data = i_master_data[g*DATA_W +: DATA_W];
        gnt_last = i_master_last[g];
      end
    end
  end

  assign can_acc  = !o_slave_valid || i_slave_ready;
  assign xfer     = gnt_vld && can_acc;
  assign gnt_next = (32'(gnt) == PORTS_N - 1) ? '0 : gnt + SEL_W'(1);

  always_comb begin
    o_master_ready = '0;
    for (int unsigned g = 0; g < PORTS_N; g++) begin
      o_master_ready[g] = can_acc && gnt_vld && (gnt == SEL_W'(g)) && !i_reset;
    end
  end

  // Output register, packet-lock FSM and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_slave_valid <= 1'b0;
      o_slave_data  <= '0;
      o_slave_last  <= 1'b0;
      o_slave_id    <= '0;
      state         <= IDLE;
      lock_id       <= '0;
      rr_ptr        <= '0;
    end else if (xfer) begin
      o_slave_valid <= 1'b1;
      o_slave_data  <= gnt_data;
      o_slave_last  <= gnt_last;
      o_slave_id    <= gnt;
      if (gnt_last) begin
        state  <= IDLE;
        rr_ptr <= gnt_next;
      end else if (state == IDLE) begin
        state   <= LOCKED;
        lock_id <= gnt;
      end
    end else if (i_slave_ready) begin
      o_slave_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uniter_rr.sv
// Bench for uniter_rr: a 4-port and a 3-port instance checked each cycle
// against a packet-level arbitration model, plus directed literal checks.
module tb_uniter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0 drives the 4-port instance, index 1 the 3-port instance
  logic         rst  [2];
  logic         mode [2];
  logic [1:0]   sel  [2];
  logic [3:0]   vld  [2];
  logic [3:0]   lst  [2];
  logic [127:0] dat  [2];
  logic         srdy [2];

  logic [3:0]  rdy4;
  logic        sv4, sl4;
  logic [31:0] sd4;
  logic [1:0]  sid4;
  logic [2:0]  rdy3;
  logic        sv3, sl3;
  logic [31:0] sd3;
  logic [1:0]  sid3;

  uniter_rr #(.PORTS_N(4), .DATA_W(32)) dut4 (
    .i_clk(clk), .i_reset(rst[0]), .i_mode(mode[0]), .i_sel(sel[0]),
    .i_master_valid(vld[0]), .o_master_ready(rdy4), .i_master_data(dat[0]),
    .i_master_last(lst[0]), .o_slave_valid(sv4), .i_slave_ready(srdy[0]),
    .o_slave_data(sd4), .o_slave_last(sl4), .o_slave_id(sid4)
  );

  uniter_rr #(.PORTS_N(3), .DATA_W(32)) dut3 (
    .i_clk(clk), .i_reset(rst[1]), .i_mode(mode[1]), .i_sel(sel[1]),
    .i_master_valid(vld[1][2:0]), .o_master_ready(rdy3), .i_master_data(dat[1][95:0]),
    .i_master_last(lst[1][2:0]), .o_slave_valid(sv3), .i_slave_ready(srdy[1]),
    .o_slave_data(sd3), .o_slave_last(sl3), .o_slave_id(sid3)
  );

  // Model: packet owner (-1 = none), next rr start, and the beat the slave should see
  int          nports [2] = '{4, 3};
  int          owner  [2];
  int          ptr    [2];
  bit          known  [2];
  bit          ov     [2];
  bit          ol     [2];
  logic [31:0] od     [2];
  int          oid    [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_gnt(input int d, output int g, output bit gv);
    g  = 0;
    gv = 1'b0;
    if (owner[d] >= 0) begin
      g  = owner[d];
      gv = vld[d][g];
    end else if (!mode[d]) begin
      g  = int'(sel[d]);
      gv = (g < nports[d]) && vld[d][g];
    end else begin
      for (int k = 0; k < nports[d]; k++) begin
        int i;
        i = (ptr[d] + k) % nports[d];
        if (!gv && vld[d][i]) begin
          g  = i;
          gv = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_dut(input int d);
    int g;
    bit gv, can;
    logic [3:0] er, ar;
    logic av, al;
    logic [31:0] ad;
    logic [1:0] aid;
    if (!known[d]) return;
    model_gnt(d, g, gv);
    can = !ov[d] || srdy[d];
    er  = (!rst[d] && can && gv) ? 4'(1 << g) : 4'h0;
    if (d == 0) begin ar = rdy4; av = sv4; al = sl4; ad = sd4; aid = sid4; end
    else        begin ar = {1'b0, rdy3}; av = sv3; al = sl3; ad = sd3; aid = sid3; end
    chk($sformatf("p%0d ready", nports[d]), 64'(ar), 64'(er));
    chk($sformatf("p%0d valid", nports[d]), 64'(av), 64'(ov[d]));
    if (ov[d]) begin
      chk($sformatf("p%0d data", nports[d]), 64'(ad), 64'(od[d]));
      chk($sformatf("p%0d last", nports[d]), 64'(al), 64'(ol[d]));
      chk($sformatf("p%0d id", nports[d]), 64'(aid), 64'(oid[d]));
    end
  endtask

  task automatic advance(input int d);
    int g;
    bit gv, can;
    model_gnt(d, g, gv);
    can = !ov[d] || srdy[d];
    if (rst[d]) begin
      known[d] = 1'b1;
      ov[d] = 1'b0; ol[d] = 1'b0; od[d] = '0; oid[d] = 0;
      owner[d] = -1; ptr[d] = 0;
    end else if (gv && can) begin
      ov[d]  = 1'b1;
      od[d]  = dat[d][g*32 +: 32];
      ol[d]  = lst[d][g];
      oid[d] = g;
      if (ol[d]) begin
        owner[d] = -1;
        ptr[d]   = (g + 1) % nports[d];
      end else begin
        owner[d] = g;
      end
    end else if (srdy[d]) begin
      ov[d] = 1'b0;
    end
  endtask

  // Inputs are set just after a negedge; check, step the model, cross the posedge
  task automatic tick();
    #1;
    check_dut(0);
    check_dut(1);
    advance(0);
    advance(1);
    @(negedge clk);
  endtask

  task automatic reset_dut(input int d);
    rst[d] = 1'b1;
    tick();
    tick();
    rst[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mode[d] = 1'b0; sel[d] = '0; vld[d] = '0; lst[d] = '0;
      dat[d] = '0; srdy[d] = 1'b1;
      owner[d] = -1; ptr[d] = 0; known[d] = 1'b0;
      ov[d] = 1'b0; ol[d] = 1'b0; od[d] = '0; oid[d] = 0;
    end
    @(negedge clk);

    // Reset with all masters valid, then round-robin starts at port 0
    vld[0] = 4'hF;
    tick();
    chk("reset valid", 64'(sv4), 64'd0);
    #1 chk("reset ready", 64'(rdy4), 64'd0);
    tick();
    chk("reset valid2", 64'(sv4), 64'd0);
    rst[0] = 1'b0; mode[0] = 1'b1; lst[0] = 4'hF; srdy[0] = 1'b1;
    #1 chk("rr first ready", 64'(rdy4), 64'h1);
    for (int i = 0; i < 5; i++) begin
      dat[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      chk("rr id", 64'(sid4), 64'(i % 4));
    end

    // Packet lock: port1 sends three beats while port2 waits
    reset_dut(0);
    mode[0] = 1'b1; vld[0] = 4'b0110; lst[0] = 4'b0000;
    tick(); chk("lock id1", 64'(sid4), 64'd1);
    tick(); chk("lock id2", 64'(sid4), 64'd1);
    lst[0] = 4'b0010;
    tick(); chk("lock id3", 64'(sid4), 64'd1);
    vld[0] = 4'b0100; lst[0] = 4'b0100;
    tick(); chk("lock id4", 64'(sid4), 64'd2);

    // Lock overrides sel
    reset_dut(0);
    mode[0] = 1'b0; sel[0] = 2'd0; vld[0] = 4'hF; lst[0] = 4'b0000;
    tick(); chk("sel lock a", 64'(sid4), 64'd0);
    sel[0] = 2'd3;
    tick(); chk("sel lock b", 64'(sid4), 64'd0);
    lst[0] = 4'b0001;
    tick(); chk("sel lock c", 64'(sid4), 64'd0);
    lst[0] = 4'b1001;
    tick(); chk("sel lock d", 64'(sid4), 64'd3);

    // Backpressure: held beat stays stable, no master is ready
    held = sd4;
    srdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dat[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1 chk("bp ready", 64'(rdy4), 64'd0);
      tick();
      chk("bp data", 64'(sd4), 64'(held));
      chk("bp id", 64'(sid4), 64'd3);
    end
    srdy[0] = 1'b1;
    dat[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    held = dat[0][127:96];
    tick();
    chk("bp resume data", 64'(sd4), 64'(held));
    chk("bp resume valid", 64'(sv4), 64'd1);

    // Three ports: out-of-range sel, then round-robin wrap after port 2
    rst[0] = 1'b1;
    reset_dut(1);
    mode[1] = 1'b0; sel[1] = 2'd3; vld[1] = 4'b0111; lst[1] = 4'b0111; srdy[1] = 1'b1;
    #1 chk("bad sel ready", 64'(rdy3), 64'd0);
    tick();
    chk("bad sel valid", 64'(sv3), 64'd0);
    mode[1] = 1'b1; vld[1] = 4'b0100;
    tick(); chk("wrap id2", 64'(sid3), 64'd2);
    vld[1] = 4'b0111;
    tick(); chk("wrap id0", 64'(sid3), 64'd0);

    // Randomized traffic on both instances
    rst[0] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 49) == 0) mode[d] = ~mode[d];
        sel[d] = 2'($urandom_range(0, 3));
        for (int p = 0; p < 4; p++) begin
          vld[d][p] = ($urandom_range(0, 9) < 7);
          lst[d][p] = ($urandom_range(0, 9) < 4);
        end
        dat[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
        srdy[d] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
